// File: rtl/activation_stage_pkg.sv
// -----------------------------------------------------------------------------
// activation_stage_pkg
// Shared definitions for the post-pool activation stage:
//   - activation mode encodings (ACT_RELU, ACT_TANH, ACT_LEAKY, ACT_IDENT)
//   - tanh piecewise-linear region codes (REG_LIN, REG_SLOPE, REG_SAT)
//   - default geometry and tanh breakpoints
//   - helper computing the tanh saturation level from the two breakpoints
// -----------------------------------------------------------------------------
package activation_stage_pkg;

    localparam logic [1:0] ACT_RELU  = 2'd0;
    localparam logic [1:0] ACT_TANH  = 2'd1;
    localparam logic [1:0] ACT_LEAKY = 2'd2;
    localparam logic [1:0] ACT_IDENT = 2'd3;

    typedef enum logic [1:0] {
        REG_LIN   = 2'd0,
        REG_SLOPE = 2'd1,
        REG_SAT   = 2'd2
    } tanh_region_e;

    localparam int DEF_DESIGN_SIZE = 16;
    localparam int DEF_DWIDTH      = 8;
    localparam int DEF_TANH_T1     = 32;
    localparam int DEF_TANH_T2     = 96;

    // Saturation level sits where the half-slope segment ends, which keeps
    // the curve continuous at the upper breakpoint.
    function automatic int tanh_sat_level(input int t1, input int t2);
        return t1 + ((t2 - t1) / 2);
    endfunction

endpackage

// File: rtl/activation_stage_lane.sv
// -----------------------------------------------------------------------------
// activation_lane
// One lane of the activation pipeline. S1 captures sign, magnitude (one bit
// wider than the element so the most negative value does not overflow), the
// raw element, the tanh region and the mask bit. S2 registers the selected
// nonlinearity result; it is forced to 0 when S1 holds no valid vector.
//
// Optional feature: ACTIVATION_LEAKY_RELU_EN enables leaky ReLU (x >>> 3 for
// negative x) on mode ACT_LEAKY; without it that mode behaves as ReLU.
//
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   i_enable       0 holds all lane state cleared
//   i_x            element for this lane (two's complement)
//   i_mask         lane enable captured with the element
//   i_s1_act_type  activation mode registered alongside S1 (from the top)
//   i_s1_valid     S1 holds a valid vector (from the top)
//   o_y            activated element, registered in S2
// -----------------------------------------------------------------------------
module activation_lane
    import activation_stage_pkg::*;
#(
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int TANH_T1 = DEF_TANH_T1,
    parameter int TANH_T2 = DEF_TANH_T2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic [DWIDTH-1:0] i_x,
    input  logic              i_mask,
    input  logic [1:0]        i_s1_act_type,
    input  logic              i_s1_valid,
    output logic [DWIDTH-1:0] o_y
);

    localparam int            MW     = DWIDTH + 1;
    localparam logic [MW-1:0] LP_ONE = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] LP_T1  = MW'(TANH_T1);
    localparam logic [MW-1:0] LP_T2  = MW'(TANH_T2);
    localparam logic [MW-1:0] LP_SAT = MW'(tanh_sat_level(TANH_T1, TANH_T2));

    logic              w_clear;
    logic [MW-1:0]     w_x_ext;
    logic [MW-1:0]     w_abs;
    tanh_region_e      w_region;

    logic              r_sign;
    logic [MW-1:0]     r_mag;
    logic [DWIDTH-1:0] r_x;
    tanh_region_e      r_region;
    logic              r_mask;

    logic [MW-1:0]     w_slope_mag;
    logic [MW-1:0]     w_tanh_mag;
    logic [MW-1:0]     w_tanh_signed;
    logic [DWIDTH-1:0] w_tanh;
    logic [DWIDTH-1:0] w_relu;
    logic [DWIDTH-1:0] w_y;
`ifdef ACTIVATION_LEAKY_RELU_EN
    logic signed [DWIDTH-1:0] w_x_sgn;
    logic [DWIDTH-1:0]        w_leaky;
`endif

    logic [DWIDTH-1:0] r_y;

    assign w_clear = reset | ~i_enable;

    // S1 front end: sign-extend, take magnitude, classify tanh region
    always_comb begin
        w_x_ext = {i_x[DWIDTH-1], i_x};
        if (i_x[DWIDTH-1]) begin
            w_abs = (~w_x_ext) + LP_ONE;
        end else begin
            w_abs = w_x_ext;
        end
        if (w_abs < LP_T1) begin
            w_region = REG_LIN;
        end else if (w_abs < LP_T2) begin
            w_region = REG_SLOPE;
        end else begin
            w_region = REG_SAT;
        end
    end

    // S1 registers
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_sign   <= 1'b0;
            r_mag    <= {MW{1'b0}};
            r_x      <= {DWIDTH{1'b0}};
            r_region <= REG_LIN;
            r_mask   <= 1'b0;
        end else begin
            r_sign   <= i_x[DWIDTH-1];
            r_mag    <= w_abs;
            r_x      <= i_x;
            r_region <= w_region;
            r_mask   <= i_mask;
        end
    end

`ifdef ACTIVATION_LEAKY_RELU_EN
    assign w_x_sgn = $signed(r_x);
    assign w_leaky = r_sign ? $unsigned(w_x_sgn >>> 3'd3) : r_x;
`endif

    // S2 function evaluation and mode select
    always_comb begin
        // Half-slope segment: T1 + (m - T1)/2, continuous with identity at T1.
        w_slope_mag = LP_T1 + ((r_mag - LP_T1) >> 1'b1);
        case (r_region)
            REG_LIN:   w_tanh_mag = r_mag;
            REG_SLOPE: w_tanh_mag = w_slope_mag;
            REG_SAT:   w_tanh_mag = LP_SAT;
            default:   w_tanh_mag = LP_SAT;
        endcase
        // Magnitude never exceeds the saturation level, so re-applying the
        // sign and truncating to DWIDTH bits is exact.
        if (r_sign) begin
            w_tanh_signed = (~w_tanh_mag) + LP_ONE;
        end else begin
            w_tanh_signed = w_tanh_mag;
        end
        w_tanh = w_tanh_signed[DWIDTH-1:0];

        if (r_sign) begin
            w_relu = {DWIDTH{1'b0}};
        end else begin
            w_relu = r_x;
        end

        if (!r_mask) begin
            w_y = {DWIDTH{1'b0}};
        end else begin
            case (i_s1_act_type)
                ACT_RELU:  w_y = w_relu;
                ACT_TANH:  w_y = w_tanh;
`ifdef ACTIVATION_LEAKY_RELU_EN
                ACT_LEAKY: w_y = w_leaky;
`else
                ACT_LEAKY: w_y = w_relu;
`endif
                ACT_IDENT: w_y = r_x;
                default:   w_y = w_relu;
            endcase
        end
    end

    // S2 result register; idle cycles carry 0
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_y <= {DWIDTH{1'b0}};
        end else if (i_s1_valid) begin
            r_y <= w_y;
        end else begin
            r_y <= {DWIDTH{1'b0}};
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/activation_stage.sv
// -----------------------------------------------------------------------------
// activation_stage
// Post-pool activation stage: applies ReLU / tanh-PWL / leaky ReLU / identity
// per lane over a DESIGN_SIZE-lane vector stream with a fixed 2-cycle latency
// and one vector per cycle. Signals completion of each DESIGN_SIZE-vector
// batch on done_activation. When enable_activation is 0 the block is a
// combinational pass-through and its state is held cleared.
//
// Optional feature: ACTIVATION_LEAKY_RELU_EN (leaky ReLU on activation_type 2).
//
// Ports:
//   clk                 clock
//   reset               synchronous, active-high reset
//   enable_activation   1 = process, 0 = bypass
//   activation_type     0 ReLU, 1 tanh-PWL, 2 leaky ReLU, 3 identity
//   in_data_available   inp_data valid this cycle
//   inp_data            lane i at [i*DWIDTH +: DWIDTH]
//   validity_mask       per-lane enable; masked lanes produce 0
//   out_data            activated vector
//   out_data_available  out_data valid this cycle
//   done_activation     batch of DESIGN_SIZE vectors fully emitted
// -----------------------------------------------------------------------------
module activation_stage
    import activation_stage_pkg::*;
#(
    parameter int DESIGN_SIZE = DEF_DESIGN_SIZE,
    parameter int DWIDTH      = DEF_DWIDTH,
    parameter int TANH_T1     = DEF_TANH_T1,
    parameter int TANH_T2     = DEF_TANH_T2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_activation,
    input  logic [1:0]                    activation_type,
    input  logic                          in_data_available,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] inp_data,
    input  logic [DESIGN_SIZE-1:0]        validity_mask,
    output logic [DESIGN_SIZE*DWIDTH-1:0] out_data,
    output logic                          out_data_available,
    output logic                          done_activation
);

    localparam int               CNT_W   = $clog2(DESIGN_SIZE + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DESIGN_SIZE - 1);
    localparam logic [CNT_W-1:0] LP_INC  = CNT_W'(1);

    logic                          w_clear;
    logic [DESIGN_SIZE*DWIDTH-1:0] w_s2_data;

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [1:0]       r_s1_type;
    logic [CNT_W-1:0] r_out_count;
    logic             r_done;

    assign w_clear = reset | ~enable_activation;

    // Valid pipeline and the mode sampled together with the S1 data
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_type  <= ACT_RELU;
        end else begin
            r_s1_valid <= in_data_available;
            r_s2_valid <= r_s1_valid;
            r_s1_type  <= activation_type;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DESIGN_SIZE; g = g + 1) begin : gen_lane
            activation_lane #(
                .DWIDTH  (DWIDTH),
                .TANH_T1 (TANH_T1),
                .TANH_T2 (TANH_T2)
            ) u_lane (
                .clk           (clk),
                .reset         (reset),
                .i_enable      (enable_activation),
                .i_x           (inp_data[g*DWIDTH +: DWIDTH]),
                .i_mask        (validity_mask[g]),
                .i_s1_act_type (r_s1_type),
                .i_s1_valid    (r_s1_valid),
                .o_y           (w_s2_data[g*DWIDTH +: DWIDTH])
            );
        end
    endgenerate

    // Output counter and batch-done flag
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_out_count <= {CNT_W{1'b0}};
            r_done      <= 1'b0;
        end else if (r_s2_valid && (r_out_count == LP_LAST)) begin
            // Final output of the batch: done wins over a coincident new
            // input so it is visible for at least one cycle.
            r_out_count <= {CNT_W{1'b0}};
            r_done      <= 1'b1;
        end else begin
            if (r_s2_valid) begin
                r_out_count <= r_out_count + LP_INC;
            end else begin
                r_out_count <= r_out_count;
            end
            if (in_data_available) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
        end
    end

    // Bypass mux: pass-through is purely combinational when disabled
    always_comb begin
        if (enable_activation) begin
            out_data           = w_s2_data;
            out_data_available = r_s2_valid;
            done_activation    = r_done;
        end else begin
            out_data           = inp_data;
            out_data_available = in_data_available;
            done_activation    = 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_stage.sv
// -----------------------------------------------------------------------------
// tb_activation_stage
// Directed-vector bench for activation_stage with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_activation_stage;
    import activation_stage_pkg::*;

    logic         clk;
    logic         reset;
    logic         enable_activation;
    logic [1:0]   activation_type;
    logic         in_data_available;
    logic [127:0] inp_data;
    logic [15:0]  validity_mask;
    logic [127:0] out_data;
    logic         out_data_available;
    logic         done_activation;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tv_in  [16];
    logic [7:0] tv_exp [16];

    activation_stage dut (
        .clk                (clk),
        .reset              (reset),
        .enable_activation  (enable_activation),
        .activation_type    (activation_type),
        .in_data_available  (in_data_available),
        .inp_data           (inp_data),
        .validity_mask      (validity_mask),
        .out_data           (out_data),
        .out_data_available (out_data_available),
        .done_activation    (done_activation)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One vector from tv_in/tv_exp; inputs are perturbed after sampling to
    // show mode and mask travel with the data.
    task automatic run_vec(input string tag, input logic [1:0] typ, input logic [15:0] mask);
        logic [127:0] din;
        logic [127:0] dexp;
        for (int i = 0; i < 16; i++) begin
            din[i*8 +: 8]  = tv_in[i];
            dexp[i*8 +: 8] = tv_exp[i];
        end
        inp_data          = din;
        validity_mask     = mask;
        activation_type   = typ;
        in_data_available = 1'b1;
        step();
        in_data_available = 1'b0;
        inp_data          = ~din;
        validity_mask     = ~mask;
        activation_type   = ~typ;
        check_eq({tag, "_lat1"}, 128'(out_data_available), 128'd0);
        step();
        check_eq({tag, "_avail"}, 128'(out_data_available), 128'd1);
        check_eq({tag, "_data"}, out_data, dexp);
        step();
    endtask

    // 16 back-to-back vectors, vector k = all lanes (k-8), even k ReLU,
    // odd k identity; checks latency, data, done timing and done clear.
    task automatic run_batch(input string tag);
        logic [7:0] ev [16];
        logic [7:0] v;
        for (int k = 0; k < 16; k++) begin
            v = 8'(k) - 8'd8;
            if ((k % 2) == 0 && v[7]) ev[k] = 8'd0;
            else                      ev[k] = v;
        end
        for (int c = 0; c < 20; c++) begin
            if (c >= 2 && c <= 17) begin
                check_eq({tag, "_avail"}, 128'(out_data_available), 128'd1);
                check_eq({tag, "_data"}, out_data, {16{ev[c-2]}});
            end else begin
                check_eq({tag, "_idle"}, 128'(out_data_available), 128'd0);
            end
            check_eq({tag, "_done"}, 128'(done_activation), (c >= 18) ? 128'd1 : 128'd0);
            if (c < 16) begin
                v                 = 8'(c) - 8'd8;
                inp_data          = {16{v}};
                activation_type   = ((c % 2) == 1) ? ACT_IDENT : ACT_RELU;
                validity_mask     = 16'hFFFF;
                in_data_available = 1'b1;
            end else begin
                in_data_available = 1'b0;
            end
            step();
        end
        check_eq({tag, "_done_hold"}, 128'(done_activation), 128'd1);
        inp_data          = {16{8'h03}};
        in_data_available = 1'b1;
        step();
        in_data_available = 1'b0;
        check_eq({tag, "_done_clr"}, 128'(done_activation), 128'd0);
        step();
        step();
        step();
    endtask

    initial begin
        logic [127:0] pat;
        reset             = 1'b1;
        enable_activation = 1'b1;
        activation_type   = ACT_RELU;
        in_data_available = 1'b0;
        inp_data          = 128'd0;
        validity_mask     = 16'hFFFF;
        step();
        step();
        check_eq("rst_data", out_data, 128'd0);
        check_eq("rst_avail", 128'(out_data_available), 128'd0);
        check_eq("rst_done", 128'(done_activation), 128'd0);
        reset = 1'b0;
        step();

        tv_in  = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'hF6, 8'h0A, 8'hF6,
                   8'h0A, 8'hF6, 8'h0A, 8'hF6, 8'h0A, 8'hF6, 8'h0A, 8'hF6};
        tv_exp = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h00, 8'h0A, 8'h00,
                   8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h0A, 8'h00};
        run_vec("relu", ACT_RELU, 16'hFFFF);

        tv_in  = '{8'h80, 8'hA0, 8'hD8, 8'hE1, 8'h00, 8'h1F, 8'h20, 8'h28,
                   8'h5F, 8'h60, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tv_exp = '{8'hC0, 8'hC0, 8'hDC, 8'hE1, 8'h00, 8'h1F, 8'h20, 8'h24,
                   8'h3F, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_vec("tanh", ACT_TANH, 16'hFFFF);

        tv_exp = '{8'h00, 8'hA0, 8'hD8, 8'hE1, 8'h00, 8'h1F, 8'h20, 8'h28,
                   8'h5F, 8'h60, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_vec("ident", ACT_IDENT, 16'hFFFE);

        for (int i = 0; i < 16; i++) begin
            tv_in[i]  = 8'h05;
            tv_exp[i] = (i < 8) ? 8'h05 : 8'h00;
        end
        run_vec("mask", ACT_RELU, 16'h00FF);

        tv_in  = '{8'h80, 8'hF8, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef ACTIVATION_LEAKY_RELU_EN
        tv_exp = '{8'hF0, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
        tv_exp = '{8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
        run_vec("leaky", ACT_LEAKY, 16'hFFFF);

        // Bypass: combinational pass-through, done forced high
        pat               = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        enable_activation = 1'b0;
        inp_data          = pat;
        in_data_available = 1'b1;
        #1;
        check_eq("byp_data", out_data, pat);
        check_eq("byp_avail", 128'(out_data_available), 128'd1);
        check_eq("byp_done", 128'(done_activation), 128'd1);
        in_data_available = 1'b0;
        #1;
        check_eq("byp_avail0", 128'(out_data_available), 128'd0);
        step();
        enable_activation = 1'b1;
        #1;
        check_eq("byp_exit_done", 128'(done_activation), 128'd0);

        run_batch("batch1");

        // Reset after the 7th vector of a batch discards it
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            inp_data          = {16{8'h11}};
            activation_type   = ACT_RELU;
            in_data_available = 1'b1;
            step();
        end
        in_data_available = 1'b0;
        reset             = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_avail", 128'(out_data_available), 128'd0);
        check_eq("mid_rst_data", out_data, 128'd0);
        check_eq("mid_rst_done", 128'(done_activation), 128'd0);
        step();
        check_eq("mid_rst_avail2", 128'(out_data_available), 128'd0);
        check_eq("mid_rst_done2", 128'(done_activation), 128'd0);

        run_batch("batch2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
